// File: rtl/log2_frac_seq_pkg.sv
// Shared types and sizing helpers for the
// sequential fixed-point log2 unit.
package lau_pkg;

  typedef enum logic [0:0] {
    FAST,
    SLOW
  } speed_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  function automatic int z_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int cnt_w(input int f);
    return (f > 0) ? $clog2(f + 1) : 1;
  endfunction

  function automatic int frac_w(input int f);
    return (f > 0) ? f : 1;
  endfunction

endpackage

// File: rtl/log2_frac_seq_log2.sv
// Combinational integer log2: index of the
// highest set bit of A (0 when A is zero).
module Log2
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0]         A,
  output logic [z_w(width)-1:0]    Z
);

  localparam int ZW = z_w(width);

  if (speed == FAST) begin : g_fast
    // Top-down scan: first set bit from the MSB wins
    always_comb begin
      Z = '0;
      for (int i = width - 1; i >= 0; i--) begin
        if (A[i] && Z == '0) Z = ZW'(i);
      end
    end
  end else begin : g_slow
    // Bottom-up scan: last set bit seen wins
    always_comb begin
      Z = '0;
      for (int i = 0; i < width; i++) begin
        if (A[i]) Z = ZW'(i);
      end
    end
  end

endmodule

// File: rtl/log2_frac_seq.sv
// Sequential log2: integer part from Log2,
// fraction by repeated mantissa squaring.
module log2_frac_seq
  import lau_pkg::*;
#(
  parameter int     width     = 8,
  parameter int     fracWidth = 4,
  parameter speed_e speed     = FAST
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [width-1:0]              A,
  input  logic                          AValid,
  output logic                          AReady,
  output logic [z_w(width)-1:0]         Z,
  output logic [frac_w(fracWidth)-1:0]  ZFrac,
  output logic                          ZZero,
  output logic                          ZValid,
  input  logic                          ZReady
);

  localparam int ZW = z_w(width);
  localparam int FW = frac_w(fracWidth);
  localparam int CW = cnt_w(fracWidth);
  localparam int SW = 2 * width;

  state_e            state_q, state_d;
  logic [width-1:0]  m_q, m_d;
  logic [ZW-1:0]     z_q, z_d;
  logic [FW-1:0]     zfrac_q, zfrac_d;
  logic              zzero_q, zzero_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [ZW-1:0]     lz;
  logic [ZW-1:0]     sh;
  logic [SW-1:0]     sq;
  logic [SW-1:0]     sqn;
  logic [width-1:0]  m_nxt;
  logic              fbit;

  Log2 #(
    .width (width),
    .speed (speed)
  ) u_log2 (
    .A (A),
    .Z (lz)
  );

  // One squaring step: renormalise S into [1,2) and emit a bit
  always_comb begin
    sh    = ZW'(width - 1) - lz;
    sq    = SW'(m_q) * SW'(m_q);
    fbit  = sq[SW-1];
    sqn   = fbit ? sq : (sq << 1);
    m_nxt = width'(sqn >> width);
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    z_d     = z_q;
    zfrac_d = zfrac_q;
    zzero_d = zzero_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (AValid) begin
          zfrac_d = '0;
          cnt_d   = CW'(fracWidth);
          if (A == '0) begin
            z_d     = '0;
            m_d     = '0;
            zzero_d = 1'b1;
            state_d = DONE;
          end else begin
            z_d     = lz;
            m_d     = A << sh;
            zzero_d = 1'b0;
            state_d = (fracWidth > 0) ? ITER : DONE;
          end
        end
      end
      ITER: begin
        m_d     = m_nxt;
        zfrac_d = (zfrac_q << 1) | FW'(fbit);
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (ZReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      m_q     <= '0;
      z_q     <= '0;
      zfrac_q <= '0;
      zzero_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      z_q     <= z_d;
      zfrac_q <= zfrac_d;
      zzero_q <= zzero_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from state or taken straight from flops
  always_comb begin
    AReady = (state_q == IDLE);
    ZValid = (state_q == DONE);
    Z      = z_q;
    ZFrac  = zfrac_q;
    ZZero  = zzero_q;
  end

endmodule
